// File: rtl/serial_responder.sv
`default_nettype none
// ============================================================================
// Module   : serial_responder
// Purpose  : Byte-level command responder between UART RX and TX. Parses
//            'R' addr / 'W' addr data commands, performs single-byte accesses
//            on a synchronous memory port and returns one reply byte.
// Revision : 1.0 - initial release
// ============================================================================
module serial_responder #(
  parameter int TIMEOUT    = 12000000,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_dat,
  input  logic                  rx_stb,
  output logic                  rx_rdy,
  output logic [7:0]            tx_dat,
  output logic                  tx_stb,
  input  logic                  tx_rdy,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [7:0]            mem_wdat,
  input  logic [7:0]            mem_rdat
);

  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] REPLY_OK  = 8'h4B;
  localparam logic [7:0] REPLY_BAD = 8'h3F;

  // Counter only ever needs to hold TIMEOUT-1.
  localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t           state;
  logic             is_write;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A byte transfers only when the receiver offers it and we are ready.
  assign accept = rx_stb && rx_rdy;

  // Command FSM; every output is registered and set on the transition into
  // the state that owns it, so strobes line up exactly with their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      cnt      <= '0;
      rx_rdy   <= 1'b0;
      tx_dat   <= 8'h00;
      tx_stb   <= 1'b0;
      mem_adr  <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      mem_wdat <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt    <= '0;
          rx_rdy <= 1'b1;
          if (accept) begin
            if (rx_dat == OP_READ || rx_dat == OP_WRITE) begin
              is_write <= (rx_dat == OP_WRITE);
              state    <= S_ADDR;
            end else begin
              tx_dat <= REPLY_BAD;
              tx_stb <= 1'b1;
              rx_rdy <= 1'b0;
              state  <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (accept) begin
            cnt     <= '0;
            mem_adr <= rx_dat[ADDR_WIDTH-1:0];
            if (is_write) begin
              state <= S_DATA;
            end else begin
              mem_re <= 1'b1;
              rx_rdy <= 1'b0;
              state  <= S_READ;
            end
          end else if (cnt == LIMIT) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (accept) begin
            cnt      <= '0;
            mem_wdat <= rx_dat;
            mem_we   <= 1'b1;
            rx_rdy   <= 1'b0;
            state    <= S_WRITE;
          end else if (cnt == LIMIT) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WRITE: begin
          tx_dat <= REPLY_OK;
          tx_stb <= 1'b1;
          state  <= S_RESP;
        end

        // Memory samples the address at the end of this cycle.
        S_READ: begin
          state <= S_WAIT;
        end

        // Read data is valid exactly one cycle after the strobe.
        S_WAIT: begin
          tx_dat <= mem_rdat;
          tx_stb <= 1'b1;
          state  <= S_RESP;
        end

        S_RESP: begin
          if (tx_rdy) begin
            tx_stb <= 1'b0;
            rx_rdy <= 1'b1;
            state  <= S_IDLE;
          end
        end

        default: begin
          tx_stb <= 1'b0;
          rx_rdy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_responder
// Purpose  : Self-checking bench for serial_responder with a transaction-level
//            reference model (command rules + register array).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_responder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_rdy;
  logic [7:0] tx_dat;
  logic       tx_stb;
  logic       tx_rdy;
  logic [7:0] mem_adr;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_wdat;
  logic [7:0] mem_rdat;
  logic       mem_init;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference register contents as the host should observe them.
  logic [7:0] ref_mem [256];

  // Strobe monitor results.
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] we_adr = 8'h00;
  logic [7:0] we_dat = 8'h00;

  always #5 clk = ~clk;

  serial_responder #(.TIMEOUT(TO), .ADDR_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dat   (rx_dat),
    .rx_stb   (rx_stb),
    .rx_rdy   (rx_rdy),
    .tx_dat   (tx_dat),
    .tx_stb   (tx_stb),
    .tx_rdy   (tx_rdy),
    .mem_adr  (mem_adr),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_wdat (mem_wdat),
    .mem_rdat (mem_rdat)
  );

  // Environment memory: synchronous, read data one cycle after mem_re.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 5) & 255);
      mem_rdat <= 8'h00;
    end else begin
      if (mem_we) mem[mem_adr] <= mem_wdat;
      if (mem_re) mem_rdat <= mem[mem_adr];
    end
  end

  // Count strobe pulses (one count per high cycle).
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      we_adr = mem_adr;
      we_dat = mem_wdat;
    end
    if (mem_re) re_cnt = re_cnt + 1;
    if (mem_we && mem_re) both_cnt = both_cnt + 1;
  end

  // Present a byte and hold it until the handshake edge has passed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_dat = b;
    rx_stb = 1'b1;
    while (!rx_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rx_rdy) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte: rx_rdy never rose for byte %h", b);
    end
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  // Collect one reply; must be called straight after the last byte accept.
  task automatic get_resp(input logic [7:0] exp, input int exp_lat, input int hold, input string nm);
    int lat;
    lat = 1;
    while (!tx_stb && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (tx_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_stb: tx_stb=%b required 1 within budget", nm, tx_stb);
      return;
    end
    n_cmp++;
    if (tx_dat !== exp) begin
      n_fail++;
      $display("FAIL %s_dat: tx_dat=%h required %h", nm, tx_dat, exp);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_lat: latency=%0d required %0d", nm, lat, exp_lat);
    end
    n_cmp++;
    if (rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rxrdy: rx_rdy=%b required 0 during response", nm, rx_rdy);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx_stb !== 1'b1 || tx_dat !== exp || rx_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_hold: cyc %0d stb=%b dat=%h rdy=%b required 1/%h/0",
                 nm, i, tx_stb, tx_dat, rx_rdy, exp);
      end
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
    n_cmp++;
    if (tx_stb !== 1'b0 || rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: stb=%b rdy=%b required 0/1 after handshake", nm, tx_stb, rx_rdy);
    end
  endtask

  // Idle long enough for a partial command to expire; nothing may happen.
  task automatic abandon(input int gap, input string nm);
    int we0, re0;
    logic seen;
    we0 = we_cnt; re0 = re_cnt; seen = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (tx_stb) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || we_cnt !== we0 || re_cnt !== re0) begin
      n_fail++;
      $display("FAIL %s_abandon: stb_seen=%b we=%0d re=%0d required 0/0/0",
               nm, seen, we_cnt - we0, re_cnt - re0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_init = 1'b1;
    rx_dat = 8'h00; rx_stb = 1'b0; tx_rdy = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_rdy, tx_stb, mem_we, mem_re} !== 4'b0000 || tx_dat !== 8'h00 ||
        mem_adr !== 8'h00 || mem_wdat !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_vals: rdy=%b stb=%b we=%b re=%b dat=%h adr=%h wdat=%h required all 0",
               rx_rdy, tx_stb, mem_we, mem_re, tx_dat, mem_adr, mem_wdat);
    end
    rst = 1'b0; mem_init = 1'b0;
    #1;
    n_cmp++;
    if (rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rx_rdy=%b required 0 before first edge", rx_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: rx_rdy=%b required 1 first cycle after release", rx_rdy);
    end
  endtask

  task automatic test_write_read;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    get_resp(8'h4B, 2, 0, "wr");
    ref_mem[8'h10] = 8'hA5;
    n_cmp++;
    if (we_cnt !== we0 + 1 || we_adr !== 8'h10 || we_dat !== 8'hA5 || re_cnt !== re0) begin
      n_fail++;
      $display("FAIL wr_strobe: we=%0d adr=%h dat=%h re=%0d required 1/10/a5/0",
               we_cnt - we0, we_adr, we_dat, re_cnt - re0);
    end
    we0 = we_cnt; re0 = re_cnt;
    send_byte(8'h52); send_byte(8'h10);
    get_resp(ref_mem[8'h10], 3, 0, "rd");
    n_cmp++;
    if (re_cnt !== re0 + 1 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL rd_strobe: re=%0d we=%0d required 1/0", re_cnt - re0, we_cnt - we0);
    end
  endtask

  task automatic test_invalid;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_byte(8'h00);
    get_resp(8'h3F, 1, 0, "inv");
    n_cmp++;
    if (we_cnt !== we0 || re_cnt !== re0) begin
      n_fail++;
      $display("FAIL inv_strobe: we=%0d re=%0d required 0/0", we_cnt - we0, re_cnt - re0);
    end
    send_byte(8'h57); send_byte(8'h03); send_byte(8'h77);
    get_resp(8'h4B, 2, 0, "inv_wr");
    ref_mem[3] = 8'h77;
    send_byte(8'h52); send_byte(8'h03);
    get_resp(ref_mem[3], 3, 0, "inv_rd");
  endtask

  task automatic test_backpressure;
    send_byte(8'h52); send_byte(8'h10);
    get_resp(ref_mem[8'h10], 3, 50, "bp");
    // Back-to-back: next opcode offered with no gap after the handshake.
    send_byte(8'h00);
    get_resp(8'h3F, 1, 0, "b2b");
  endtask

  task automatic test_timeout;
    send_byte(8'h57); send_byte(8'h20);
    abandon(TO, "to");
    send_byte(8'h52); send_byte(8'h20);
    get_resp(ref_mem[8'h20], 3, 0, "to_rd");
  endtask

  task automatic test_timeout_boundary;
    int we0;
    send_byte(8'h57);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h20);
    we0 = we_cnt;
    send_byte(8'h11);
    get_resp(8'h4B, 2, 0, "tob");
    ref_mem[8'h20] = 8'h11;
    n_cmp++;
    if (we_cnt !== we0 + 1 || we_adr !== 8'h20 || we_dat !== 8'h11) begin
      n_fail++;
      $display("FAIL tob_strobe: we=%0d adr=%h dat=%h required 1/20/11",
               we_cnt - we0, we_adr, we_dat);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    // Reset while a read response is pending.
    send_byte(8'h52); send_byte(8'h10);
    n = 0;
    while (!tx_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_stb, mem_we, mem_re, rx_rdy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_resp: stb=%b we=%b re=%b rdy=%b required 0000",
               tx_stb, mem_we, mem_re, rx_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rx_rdy !== 1'b1 || tx_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rdy: rdy=%b stb=%b required 1/0", rx_rdy, tx_stb);
    end
    // Reset during the write strobe: the write must not land.
    send_byte(8'h57); send_byte(8'h45); send_byte(8'h99);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || tx_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_we: we=%b stb=%b required 0/0", mem_we, tx_stb);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h52); send_byte(8'h45);
    get_resp(ref_mem[8'h45], 3, 0, "rstmid_rd");
    send_byte(8'h57); send_byte(8'h46); send_byte(8'h5A);
    get_resp(8'h4B, 2, 0, "rt_wr");
    ref_mem[8'h46] = 8'h5A;
    send_byte(8'h52); send_byte(8'h46);
    get_resp(ref_mem[8'h46], 3, 0, "rt_rd");
  endtask

  function automatic int pick_gap();
    if ($urandom_range(0, 99) < 15) return int'($urandom_range(TO, TO + 4));
    return int'($urandom_range(0, TO - 1));
  endfunction

  task automatic test_random;
    int we0, re0, sel, g, hold;
    logic [7:0] op, adr, dat;
    for (int t = 0; t < 40; t++) begin
      we0 = we_cnt; re0 = re_cnt;
      sel = int'($urandom_range(0, 9));
      adr = 8'($urandom);
      dat = 8'($urandom);
      hold = int'($urandom_range(0, 4));
      if (sel < 4) op = 8'h52;
      else if (sel < 8) op = 8'h57;
      else begin
        op = 8'($urandom);
        while (op == 8'h52 || op == 8'h57) op = 8'($urandom);
      end
      send_byte(op);
      if (op != 8'h52 && op != 8'h57) begin
        get_resp(8'h3F, 1, hold, "rnd_inv");
        continue;
      end
      g = pick_gap();
      if (g >= TO) begin
        abandon(g, "rnd_a");
        continue;
      end
      repeat (g) @(negedge clk);
      send_byte(adr);
      if (op == 8'h52) begin
        get_resp(ref_mem[adr], 3, hold, "rnd_rd");
        n_cmp++;
        if (re_cnt !== re0 + 1 || we_cnt !== we0) begin
          n_fail++;
          $display("FAIL rnd_rd_strobe: re=%0d we=%0d required 1/0", re_cnt - re0, we_cnt - we0);
        end
        continue;
      end
      g = pick_gap();
      if (g >= TO) begin
        abandon(g, "rnd_d");
        continue;
      end
      repeat (g) @(negedge clk);
      send_byte(dat);
      get_resp(8'h4B, 2, hold, "rnd_wr");
      ref_mem[adr] = dat;
      n_cmp++;
      if (we_cnt !== we0 + 1 || we_adr !== adr || we_dat !== dat || re_cnt !== re0) begin
        n_fail++;
        $display("FAIL rnd_wr_strobe: we=%0d adr=%h dat=%h required 1/%h/%h",
                 we_cnt - we0, we_adr, we_dat, adr, dat);
      end
    end
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_excl: mem_we&mem_re cycles=%0d required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_invalid;
    test_backpressure;
    test_timeout;
    test_timeout_boundary;
    test_random;
    test_reset_mid;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_responder.md
Name: serial_responder

Overview:
- Byte-level command responder between the UART receive and transmit blocks: consumes host command bytes from the receiver, executes single-byte register reads and writes on a simple synchronous memory port, and returns one response byte per command to the transmitter.
- Gives the host end of the serial link a register access path into the design.

Parameters:
- TIMEOUT, 12000000, inter-byte timeout in clk cycles (1 s at 12 MHz); a partial command is discarded when it expires.
- ADDR_WIDTH, 8, memory port address width (1..8); address taken from the low ADDR_WIDTH bits of the address byte.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_dat  input  8  byte from receiver
- rx_stb  input  1  rx_dat valid
- rx_rdy  output  1  responder can accept a byte; transfer when rx_stb && rx_rdy
- tx_dat  output  8  response byte to transmitter
- tx_stb  output  1  tx_dat valid; held until accepted
- tx_rdy  input  1  transmitter can accept; transfer when tx_stb && tx_rdy
- mem_adr  output  ADDR_WIDTH  register address
- mem_we  output  1  one-cycle write strobe
- mem_re  output  1  one-cycle read strobe
- mem_wdat  output  8  write data
- mem_rdat  input  8  read data, valid exactly one cycle after mem_re

Behaviour:
- Reset (async assert, sync release): state IDLE; rx_rdy=0, tx_stb=0, tx_dat=0, mem_we=0, mem_re=0, mem_adr=0, mem_wdat=0, timeout counter=0. rx_rdy rises the first cycle after rst deasserts.
- Commands: 0x52 'R', addr -> reply mem[addr]. 0x57 'W', addr, data -> write, reply 0x4B 'K'. Any other first byte -> reply 0x3F '?'; no memory access.
- States and transitions:
  - IDLE: rx_rdy=1. On 0x52/0x57 -> ADDR, latch opcode. On other byte -> RESP with tx_dat=0x3F.
  - ADDR: rx_rdy=1. On byte, latch mem_adr. Read -> READ; write -> DATA.
  - DATA: rx_rdy=1. On byte, latch mem_wdat -> WRITE.
  - WRITE: mem_we=1 for one cycle; tx_dat=0x4B -> RESP.
  - READ: mem_re=1 for one cycle -> WAIT.
  - WAIT: capture mem_rdat into tx_dat -> RESP.
  - RESP: tx_stb=1, rx_rdy=0. On tx_rdy -> IDLE; tx_stb drops the same edge.
- rx_rdy=0 in WRITE, READ, WAIT and RESP. Command bytes are never dropped silently; backpressure is the receiver's responsibility.
- Latency, last command byte accepted to tx_stb high:
  - write: 2 cycles (WRITE, then RESP)
  - read: 3 cycles (READ, WAIT, RESP)
  - invalid opcode: 1 cycle
- mem_adr and mem_wdat are stable from latch until the next command latches new values. mem_we and mem_re are never both high.
- Timeout:
  - Counter clears on every accepted rx byte and on every IDLE cycle; increments in ADDR and DATA.
  - When it reaches TIMEOUT-1, next state is IDLE with no memory access and no response.
  - A byte accepted in the same cycle as expiry wins: the byte is processed and the counter clears.
- Async reset mid-command or mid-response aborts immediately to reset values. Any pending tx_stb is withdrawn; no partial response is reissued.
- tx_dat is stable for the whole time tx_stb is high.
- Back-to-back commands: the next command's first byte can be accepted the cycle after the response handshake.

Test Plan:
- Write then read: bytes 0x57,0x10,0xA5 -> one mem_we pulse with mem_adr=0x10, mem_wdat=0xA5, tx_dat=0x4B. Then 0x52,0x10 with a memory model -> mem_re pulse, tx_dat=0xA5 three cycles after the address byte.
- Invalid opcode: byte 0x00 -> tx_dat=0x3F one cycle later; no mem_we/mem_re. A following 0x52,0x03 with mem[3]=0x77 -> tx_dat=0x77.
- Backpressure: hold tx_rdy=0 for 50 cycles after a read response -> tx_stb and tx_dat stay constant and rx_rdy stays 0. Assert tx_rdy -> one transfer, then rx_rdy=1 the next cycle.
- Timeout (TIMEOUT=16): send 0x57,0x20, then idle 16 cycles -> state returns to IDLE, no mem_we, no tx_stb. A new 0x52,0x20 completes normally.
- Timeout boundary (TIMEOUT=16): send 0x57, then present 0x20 on exactly cycle 15 -> byte accepted and the command continues; a later data byte 0x11 produces the write and 0x4B.
- Reset mid-operation: assert rst while tx_stb=1 -> tx_stb, mem_we and mem_re drop asynchronously and rx_rdy=0. After release, rx_rdy=1 next cycle and a full write/read round trip passes.
